mode4_exp_accum: RTL and testbench
==================================

# mode4_exp_accum

Accumulation stage of the 4-lane softmax datapath. Consumes the four fp16 exponent results produced each cycle by the combinational exponent stage and reduces a full row (one or more 4-lane beats) to a single fp16 sum. It uses a pipelined 4:1 adder tree followed by an accumulator. The row sum feeds the downstream reciprocal/normalisation stage, with a one-cycle done pulse.

## Interface
- `DATAWIDTH`, 16 (from `defines.v`): fp16 operand width (1 sign, 5 exponent, 10 significand).
- `CNTW`, 8: width of the beat counter.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a new row; honoured only in IDLE.
- `valid_in`  input  1  `inp0..inp3` carry a beat this cycle.
- `last_in`  input  1  the current beat is the final beat of the row; qualified by `valid_in`.
- `lane_mask`  input  4  per-lane enable; bit i = 0 replaces `inp<i>` with +0 (16'h0000). Used for partial final beats.
- `inp0`..`inp3`  input  DATAWIDTH each  exponent-stage outputs.
- `in_ready`  output  1  high while in ACCUM; beats are accepted only when `in_ready && valid_in`.
- `outp`  output  DATAWIDTH  accumulated row sum; meaningful only while `outp_valid` is high.
- `outp_valid`  output  1  one-cycle pulse marking the final row sum.
- `num_beats`  output  CNTW  number of beats accepted in the current or most recent row.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE → ACCUM when `start` is high. This clears `num_beats` to 0.
  - ACCUM → DRAIN on an accepted beat with `last_in` = 1.
  - DRAIN → IDLE on the edge where the last beat is written to the accumulator. The same edge sets `outp_valid`.
- `start` is ignored in ACCUM and DRAIN.
- `valid_in` is ignored in IDLE and DRAIN; such beats are dropped and not counted.
- Accepted beat:
  - Masked lanes are forced to +0.
  - Stage 1 registers `s01 = in0 + in1` and `s23 = in2 + in3`.
  - Stage 2 registers `t = s01 + s23`.
  - Stage 3 is the accumulator `acc`.
- A `first` flag and a `last` flag travel with each beat through the valid pipeline.
  - When a beat with `first` reaches stage 3: `acc <= t`.
  - Otherwise: `acc <= acc + t`.
  - No clear cycle is needed between rows.
- All adds are fp16 with IEEE round-to-nearest-even. Four adder instances are used: two in stage 1, one in stage 2, one in the accumulator.
- `num_beats` increments on each accepted beat and saturates at 2^CNTW−1.
- `outp` is driven directly from `acc`.

## Timing
- Reset values: state IDLE; `in_ready` 0; `outp_valid` 0; `outp` 0; `num_beats` 0; all pipeline data and valid bits 0.
- `start` sampled at edge S: `in_ready` is high from S onward. The first beat can be accepted at edge S+1.
- Beat accepted at edge E:
  - stage 1 loads at E;
  - stage 2 loads at E+1;
  - `acc` updates at E+2.
- Last beat accepted at edge L:
  - `in_ready` falls at L;
  - `outp_valid` = 1 and `outp` = final sum during the cycle L+2..L+3;
  - state is IDLE from L+2.
- `start` asserted during the `outp_valid` cycle is accepted at L+3.
- Minimum row-to-row gap is therefore 3 cycles after the last beat.
- Throughput in ACCUM is one beat per cycle. Bubbles (`valid_in` = 0) are allowed and do not disturb `acc`.
- Single-beat row (first and last in the same beat): `acc <= t`, and `outp_valid` follows at L+2.
- Reset asserted mid-row: immediate return to IDLE, pipeline flushed, no `outp_valid`. The partial sum is discarded.

## Test plan
- Start, then 2 beats of all-1.0 (16'h3C00, mask 4'hF) with the second beat marked last → `outp_valid` 2 cycles after the last accept, `outp` = 16'h4800 (8.0), `num_beats` = 2.
- Single beat {1.0, 2.0, 4.0, 8.0} with last and mask 4'b0011 → `outp` = 16'h4200 (3.0), one-cycle `outp_valid`.
- 3-beat row of all-2.0 (16'h4000) with bubbles between beats, then a 2nd row started in the `outp_valid` cycle with 1 beat of 1.0 → sums 24.0 (16'h4E00) then 4.0 (16'h4400). The 2nd row's result is unaffected by the first.
- `valid_in` held high in IDLE and in DRAIN with 16'h3C00 data → those beats are not counted and the row sum is unchanged.
- Reset asserted one cycle after the 2nd beat of a 4-beat row → no `outp_valid`, all outputs 0. A fresh 1-beat row of all-1.0 then gives 16'h4400.
- `start` asserted repeatedly during ACCUM → ignored; `num_beats` is not cleared.

Source files
------------

// File: rtl/mode4_exp_accum_if.sv
// Beat/result bus of the softmax accumulation stage: four fp16 lanes in, one fp16 row sum out.
interface mode4_exp_accum_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned CNTW      = 8
);
  logic                 start;
  logic                 valid_in;
  logic                 last_in;
  logic [3:0]           lane_mask;
  logic [DATAWIDTH-1:0] inp0;
  logic [DATAWIDTH-1:0] inp1;
  logic [DATAWIDTH-1:0] inp2;
  logic [DATAWIDTH-1:0] inp3;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] outp;
  logic                 outp_valid;
  logic [CNTW-1:0]      num_beats;

  modport master (
    output start, valid_in, last_in, lane_mask, inp0, inp1, inp2, inp3,
    input  in_ready, outp, outp_valid, num_beats
  );

  modport slave (
    input  start, valid_in, last_in, lane_mask, inp0, inp1, inp2, inp3,
    output in_ready, outp, outp_valid, num_beats
  );
endinterface

// File: rtl/mode4_exp_accum.sv
// Reduces a row of 4-lane fp16 beats to one fp16 sum: 2-stage adder tree feeding an accumulator.
module mode4_exp_accum #(
  parameter int unsigned CNTW = 8
) (
  input  logic             clk,
  input  logic             reset,
  mode4_exp_accum_if.slave bus
);
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  // fp16 add, round-to-nearest-even, subnormals kept, overflow to infinity.
  function automatic logic [DW-1:0] fp16_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, sub, up;
    logic [15:0] big, sml, r;
    logic [4:0]  eb, es, d;
    logic [10:0] mb, ms;
    logic [25:0] sh;
    logic [13:0] al, ml, n;
    logic [14:0] s;
    logic [5:0]  e;
    logic [11:0] m;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    r = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      r = 16'h7e00;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else begin
      if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
      else                    begin big = b; sml = a; end
      eb  = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
      es  = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
      mb  = {big[14:10] != 5'd0, big[9:0]};
      ms  = {sml[14:10] != 5'd0, sml[9:0]};
      d   = eb - es;
      sh  = {ms, 15'd0} >> d;
      // beyond 13 positions the smaller operand only contributes to sticky
      al  = (d > 5'd13) ? {13'd0, |ms} : {sh[25:13], |sh[12:0]};
      ml  = {mb, 3'd0};
      sub = big[15] ^ sml[15];
      s   = sub ? ({1'b0, ml} - {1'b0, al}) : ({1'b0, ml} + {1'b0, al});
      e   = {1'b0, eb};
      if (s == 15'd0) begin
        r = {big[15] & sml[15], 15'd0};
      end else begin
        if (s[14]) begin
          n = {s[14:2], s[1] | s[0]};
          e = e + 6'd1;
        end else begin
          n = s[13:0];
          for (int i = 0; i < 13; i++) begin
            if (!n[13] && (e > 6'd1)) begin
              n = n << 1;
              e = e - 6'd1;
            end
          end
        end
        up = n[2] & (n[1] | n[0] | n[3]);
        m  = {1'b0, n[13:3]} + 12'(up);
        if (m[11]) begin
          m = m >> 1;
          e = e + 6'd1;
        end
        if (e >= 6'd31) r = {big[15], 5'h1f, 10'd0};
        else            r = {big[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
      end
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic            in_ready_q;
  logic [DW-1:0]   s01_q, s23_q, t_q, acc_q;
  logic            v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
  logic            outp_valid_q;
  logic [CNTW-1:0] num_beats_q;
  logic            accept_c;
  logic [DW-1:0]   in0_c, in1_c, in2_c, in3_c;

  assign accept_c = (state_q == ACCUM) && bus.valid_in;
  assign in0_c    = bus.lane_mask[0] ? bus.inp0 : '0;
  assign in1_c    = bus.lane_mask[1] ? bus.inp1 : '0;
  assign in2_c    = bus.lane_mask[2] ? bus.inp2 : '0;
  assign in3_c    = bus.lane_mask[3] ? bus.inp3 : '0;

  // Row sequencing: DRAIN ends when the last beat reaches the accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (accept_c && bus.last_in) state_d = DRAIN;
      DRAIN:   if (v2_q && l2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s01_q        <= '0;
      s23_q        <= '0;
      t_q          <= '0;
      acc_q        <= '0;
      v1_q         <= 1'b0;
      f1_q         <= 1'b0;
      l1_q         <= 1'b0;
      v2_q         <= 1'b0;
      f2_q         <= 1'b0;
      l2_q         <= 1'b0;
      outp_valid_q <= 1'b0;
      num_beats_q  <= '0;
    end else begin
      v1_q <= accept_c;
      if (accept_c) begin
        s01_q <= fp16_add(in0_c, in1_c);
        s23_q <= fp16_add(in2_c, in3_c);
        f1_q  <= (num_beats_q == '0);
        l1_q  <= bus.last_in;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        t_q  <= fp16_add(s01_q, s23_q);
        f2_q <= f1_q;
        l2_q <= l1_q;
      end
      // first beat of a row overwrites, so rows need no clear cycle
      if (v2_q) acc_q <= f2_q ? t_q : fp16_add(acc_q, t_q);
      outp_valid_q <= v2_q && l2_q;
      if ((state_q == IDLE) && bus.start) num_beats_q <= '0;
      else if (accept_c && (num_beats_q != '1)) num_beats_q <= num_beats_q + CNTW'(1);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.outp       = acc_q;
  assign bus.outp_valid = outp_valid_q;
  assign bus.num_beats  = num_beats_q;
endmodule

// File: tb/tb_mode4_exp_accum.sv
// Directed and randomized rows checked against a real-arithmetic fp16 reference model.
module tb_mode4_exp_accum;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mode4_exp_accum_if bus();
  mode4_exp_accum dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] m_sum  = 16'h0000;
  bit          m_first = 1'b1;
  bit          m_busy  = 1'b0;
  int          m_cnt   = 0;

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  ex = int'(h[14:10]);
    real v  = (ex == 0) ? real'(int'(h[9:0])) : real'(1024 + int'(h[9:0]));
    v = v * p2(((ex == 0) ? 1 : ex) - 25);
    return h[15] ? -v : v;
  endfunction

  // Nearest fp16 to an exactly representable real, ties to even.
  function automatic logic [15:0] r2h(input real x);
    bit  sgn = (x < 0.0);
    real ax  = sgn ? -x : x;
    real u, fr;
    int  e, iu;
    if (ax == 0.0) return 16'h0000;
    e = 1;
    while ((e < 31) && (ax >= p2(e - 14))) e++;
    if (e >= 31) return {sgn, 15'h7c00};
    u  = ax / p2(e - 25);
    iu = $rtoi(u);
    fr = u - real'(iu);
    if ((fr > 0.5) || ((fr == 0.5) && (iu % 2 == 1))) iu++;
    if (iu >= 2048) begin iu = iu / 2; e++; end
    if (e >= 31) return {sgn, 15'h7c00};
    return {sgn, (iu >= 1024) ? 5'(e) : 5'd0, 10'(iu)};
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] rnd_val();
    logic [4:0] ex = 5'($urandom_range(10, 20));
    return {1'($urandom), ex, 10'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.last_in = 1'b0; bus.lane_mask = 4'hf;
    bus.inp0 = '0; bus.inp1 = '0; bus.inp2 = '0; bus.inp3 = '0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_first = 1'b1; m_cnt = 0; m_busy = 1'b1;
    check("start_ready", 16'(bus.in_ready), 16'd1);
    check("start_count", 16'(bus.num_beats), 16'd0);
  endtask

  // One cycle of input; the reference accepts it only while a row is open.
  task automatic beat(input bit v, input bit l, input logic [3:0] mk,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    logic [15:0] x [4];
    logic [15:0] t;
    check("ready_pre", 16'(bus.in_ready), 16'(m_busy));
    bus.valid_in = v; bus.last_in = l; bus.lane_mask = mk;
    bus.inp0 = a; bus.inp1 = b; bus.inp2 = c; bus.inp3 = d;
    step();
    if (v && m_busy) begin
      x[0] = mk[0] ? a : 16'h0; x[1] = mk[1] ? b : 16'h0;
      x[2] = mk[2] ? c : 16'h0; x[3] = mk[3] ? d : 16'h0;
      t = fadd(fadd(x[0], x[1]), fadd(x[2], x[3]));
      m_sum   = m_first ? t : fadd(m_sum, t);
      m_first = 1'b0;
      if (m_cnt < 255) m_cnt++;
      if (l) m_busy = 1'b0;
    end
    check("num_beats", 16'(bus.num_beats), 16'(m_cnt));
  endtask

  // Called right after the last beat's edge L; walks L..L+3.
  task automatic finish_row(input bit start_next, input bit hold_valid);
    if (!hold_valid) bus.valid_in = 1'b0;
    bus.last_in = 1'b0;
    check("ready_L", 16'(bus.in_ready), 16'd0);
    check("ovalid_L", 16'(bus.outp_valid), 16'd0);
    step();
    check("ovalid_L1", 16'(bus.outp_valid), 16'd0);
    step();
    check("ovalid_L2", 16'(bus.outp_valid), 16'd1);
    check("row_sum", bus.outp, m_sum);
    check("row_beats", 16'(bus.num_beats), 16'(m_cnt));
    if (start_next) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    check("ovalid_L3", 16'(bus.outp_valid), 16'd0);
    check("ready_L3", 16'(bus.in_ready), 16'(start_next));
    if (start_next) begin
      m_first = 1'b1; m_cnt = 0; m_busy = 1'b1;
      check("restart_count", 16'(bus.num_beats), 16'd0);
    end
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    idle_inputs();
    step(); step();
    check("rst_ready", 16'(bus.in_ready), 16'd0);
    check("rst_ovalid", 16'(bus.outp_valid), 16'd0);
    check("rst_outp", bus.outp, 16'h0000);
    check("rst_beats", 16'(bus.num_beats), 16'd0);
    reset = 1'b0;
    step();

    // two beats of 1.0
    do_start();
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 1, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    finish_row(0, 0);
    check("tp1_sum", bus.outp, 16'h4800);

    // single masked beat
    do_start();
    beat(1, 1, 4'b0011, 16'h3c00, 16'h4000, 16'h4400, 16'h4800);
    finish_row(0, 0);
    check("tp2_sum", bus.outp, 16'h4200);

    // bubbles, then back-to-back row started in the result cycle
    do_start();
    beat(1, 0, 4'hf, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    beat(0, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 0, 4'hf, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    beat(0, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(0, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 1, 4'hf, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    finish_row(1, 0);
    check("tp3_sum_a", bus.outp, 16'h4e00);
    beat(1, 1, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    finish_row(0, 0);
    check("tp3_sum_b", bus.outp, 16'h4400);

    // valid_in in IDLE and DRAIN is dropped
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 1, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    do_start();
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 1, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    finish_row(0, 1);
    check("tp4_sum", bus.outp, 16'h4800);
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    bus.valid_in = 1'b0;

    // reset mid-row discards the partial sum
    do_start();
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(1, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    beat(0, 0, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 16'(bus.in_ready), 16'd0);
    check("mid_rst_ovalid", 16'(bus.outp_valid), 16'd0);
    check("mid_rst_outp", bus.outp, 16'h0000);
    check("mid_rst_beats", 16'(bus.num_beats), 16'd0);
    step();
    reset = 1'b0;
    m_busy = 1'b0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_ovalid", 16'(bus.outp_valid), 16'd0);
    end
    do_start();
    beat(1, 1, 4'hf, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    finish_row(0, 0);
    check("tp5_sum", bus.outp, 16'h4400);

    // start during ACCUM is ignored
    do_start();
    bus.start = 1'b1;
    beat(1, 0, 4'hf, 16'h3c00, 16'h4000, 16'h3c00, 16'h4000);
    beat(1, 0, 4'hf, 16'h3c00, 16'h4000, 16'h3c00, 16'h4000);
    beat(1, 1, 4'hf, 16'h3c00, 16'h4000, 16'h3c00, 16'h4000);
    bus.start = 1'b0;
    finish_row(0, 0);

    // randomized rows
    for (int r = 0; r < 8; r++) begin
      do_start();
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0)
          beat(0, 0, 4'hf, rnd_val(), rnd_val(), rnd_val(), rnd_val());
        beat(1, b == nb - 1, 4'($urandom), rnd_val(), rnd_val(), rnd_val(), rnd_val());
      end
      finish_row(r % 2 == 1, 0);
      if (r % 2 == 1) begin
        beat(1, 1, 4'hf, rnd_val(), rnd_val(), rnd_val(), rnd_val());
        finish_row(0, 0);
      end
    end

    // beat counter saturation
    do_start();
    for (int b = 0; b < 260; b++)
      beat(1, b == 259, 4'b0001, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
    finish_row(0, 0);
    check("sat_beats", 16'(bus.num_beats), 16'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
